// File: rtl/tournament_pkg.sv
// Shared types and helpers for the tournament chooser table.
package tournament_pkg;

   // Init sweep vs. normal operation
   typedef enum logic {
      TP_INIT  = 1'b0,
      TP_READY = 1'b1
   } tp_state_t;

   // Width at which PCs are handed to the index helper
   localparam int unsigned PC_ARG_W = 64;

   // Table index of a PC: word address bits above [1:0], truncated to index_bits
   function automatic logic [PC_ARG_W-1:0] pc_index(input logic [PC_ARG_W-1:0] pc,
                                                   input int unsigned         index_bits);
      logic [PC_ARG_W-1:0] mask;
      mask = (PC_ARG_W'(1) << index_bits) - PC_ARG_W'(1);
      return (pc >> 2) & mask;
   endfunction

endpackage

// File: rtl/sat_ctr_next.sv
// Saturating up/down step for one chooser counter (combinational).
module sat_ctr_next #(
   parameter int unsigned CTR_BITS = 2
) (
   input  logic [CTR_BITS-1:0] ctr,
   input  logic                inc,
   input  logic                dec,
   output logic [CTR_BITS-1:0] nxt_c
);

   localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
   localparam logic [CTR_BITS-1:0] CTR_MIN = '0;

   // Step toward global on inc, toward local on dec, clamp at both ends
   always_comb begin
      nxt_c = ctr;
      if (inc && (ctr != CTR_MAX)) begin
         nxt_c = ctr + CTR_BITS'(1);
      end else if (dec && (ctr != CTR_MIN)) begin
         nxt_c = ctr - CTR_BITS'(1);
      end
   end

endmodule

// File: rtl/tournament_chooser_table.sv
// PC-indexed table of saturating chooser counters selecting local vs. global
// branch predictions. Runs an init sweep after reset before accepting updates.
// Define TOURNAMENT_STATS_EN to add saturating update statistics outputs.
module tournament_chooser_table
   import tournament_pkg::*;
#(
   parameter int unsigned INDEX_BITS = 6,
   parameter int unsigned CTR_BITS   = 2,
   parameter int unsigned PC_WIDTH   = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [PC_WIDTH-1:0] pred_pc,
   input  logic                local_pred,
   input  logic                global_pred,
   output logic                choose_global,
   output logic                prediction,
   output logic                ready,
   input  logic                upd_valid,
   input  logic [PC_WIDTH-1:0] upd_pc,
   input  logic                upd_local_pred,
   input  logic                upd_global_pred,
   input  logic                upd_taken
`ifdef TOURNAMENT_STATS_EN
   ,
   output logic [31:0]         stat_updates,
   output logic [31:0]         stat_local_only,
   output logic [31:0]         stat_global_only
`endif
);

   localparam int unsigned DEPTH = 1 << INDEX_BITS;
   localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(DEPTH - 1);
   localparam logic [CTR_BITS-1:0]   INIT_VAL = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

   tp_state_t                state, state_nxt;
   logic [INDEX_BITS-1:0]    ptr;
   logic [CTR_BITS-1:0]      tbl [DEPTH];
   logic [INDEX_BITS-1:0]    pred_idx, upd_idx;
   logic [CTR_BITS-1:0]      upd_ctr_nxt;
   logic                     lc, gc;
   logic                     init_we_c, upd_we_c;

   assign pred_idx = INDEX_BITS'(pc_index(PC_ARG_W'(pred_pc), INDEX_BITS));
   assign upd_idx  = INDEX_BITS'(pc_index(PC_ARG_W'(upd_pc), INDEX_BITS));
   assign lc       = (upd_local_pred == upd_taken);
   assign gc       = (upd_global_pred == upd_taken);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= TP_INIT;
      else        state <= state_nxt;
   end

   // Next state: leave the sweep after writing the last entry
   always_comb begin
      state_nxt = state;
      if ((state == TP_INIT) && (ptr == LAST_IDX)) state_nxt = TP_READY;
   end

   // Write enables: sweep writes during init, training only once ready
   always_comb begin
      init_we_c = 1'b0;
      upd_we_c  = 1'b0;
      case (state)
         TP_INIT:  init_we_c = 1'b1;
         TP_READY: upd_we_c  = upd_valid;
         default:  ;
      endcase
   end

   // Sweep pointer and ready flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr   <= '0;
         ready <= 1'b0;
      end else if (init_we_c) begin
         ptr <= ptr + INDEX_BITS'(1);
         if (ptr == LAST_IDX) ready <= 1'b1;
      end
   end

   sat_ctr_next #(.CTR_BITS(CTR_BITS)) u_sat_ctr_next (
      .ctr   (tbl[upd_idx]),
      .inc   (gc & ~lc),
      .dec   (lc & ~gc),
      .nxt_c (upd_ctr_nxt)
   );

   // Table storage: sweep fill or trained counter; contents are not reset
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (init_we_c)     tbl[ptr]     <= INIT_VAL;
         else if (upd_we_c) tbl[upd_idx] <= upd_ctr_nxt;
      end
   end

   // Lookup without write bypass; forced to local until the sweep is done
   assign choose_global = ready & tbl[pred_idx][CTR_BITS-1];
   assign prediction    = choose_global ? global_pred : local_pred;

`ifdef TOURNAMENT_STATS_EN
   localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

   // Saturating counts of accepted updates by correctness class
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_updates     <= '0;
         stat_local_only  <= '0;
         stat_global_only <= '0;
      end else if (upd_we_c) begin
         if (stat_updates != STAT_MAX) stat_updates <= stat_updates + 32'd1;
         if (lc && !gc && (stat_local_only != STAT_MAX))
            stat_local_only <= stat_local_only + 32'd1;
         if (gc && !lc && (stat_global_only != STAT_MAX))
            stat_global_only <= stat_global_only + 32'd1;
      end
   end
`endif

endmodule
